// File: rtl/dsp_capture_pkg.sv
// Shared types and default widths for the BRAM capture sequencer.
package dsp_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capture_state_t;

  localparam int unsigned CAP_ADDRWIDTH = 13;
  localparam int unsigned CAP_DATAWIDTH = 64;

endpackage

// File: rtl/capture_trig_detect.sv
// Trigger source merge for the capture sequencer: software pulse, immediate mode,
// or a rising edge on the external trigger level. Only fires while armed.
module capture_trig_detect
  import dsp_capture_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic armed,
  input  logic trig_mode,
  input  logic trig_in,
  input  logic sw_trig,
  output logic trig_evt
);

  logic trig_in_q;

  // Previous trigger level, tracked every cycle so a level already high at arm is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_in_q <= 1'b0;
    end else begin
      trig_in_q <= trig_in;
    end
  end

  assign trig_evt = armed & (sw_trig | ~trig_mode | (trig_in & ~trig_in_q));

endmodule

// File: rtl/bram_capture_ctrl.sv
// Arm/trigger/capture sequencer driving a to-host BRAM write port.
// After arm it waits for a trigger, then writes exactly nsamp_eff samples of din
// starting at address 0, never wrapping. Optional decimation via CAPTURE_DECIM_EN.
module bram_capture_ctrl
  import dsp_capture_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = CAP_ADDRWIDTH,
  parameter int unsigned DATAWIDTH = CAP_DATAWIDTH
`ifdef CAPTURE_DECIM_EN
  ,
  parameter int unsigned DECIMWIDTH = 8
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trig_mode,
  input  logic                   trig_in,
  input  logic                   sw_trig,
  input  logic [ADDRWIDTH:0]     nsamp,
`ifdef CAPTURE_DECIM_EN
  input  logic [DECIMWIDTH-1:0]  decim,
`endif
  input  logic [DATAWIDTH-1:0]   din,
  output logic [ADDRWIDTH-1:0]   bram_addr,
  output logic [DATAWIDTH-1:0]   bram_data,
  output logic [DATAWIDTH/8-1:0] bram_we,
  output logic                   busy,
  output logic                   done,
  output logic [ADDRWIDTH:0]     wr_count,
  output logic [1:0]             state
);

  localparam int unsigned WeWidth = DATAWIDTH / 8;
  localparam logic [ADDRWIDTH:0] Depth   = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [ADDRWIDTH:0] CntOne  = {{ADDRWIDTH{1'b0}}, 1'b1};

  // 0 and anything beyond the buffer both mean "fill the whole buffer"
  function automatic logic [ADDRWIDTH:0] clamp_nsamp(input logic [ADDRWIDTH:0] n);
    if (n == '0 || n > Depth) return Depth;
    return n;
  endfunction

  capture_state_t         state_q, state_d;
  logic [ADDRWIDTH:0]     nsamp_q;
  logic [ADDRWIDTH:0]     wr_count_q;
  logic [ADDRWIDTH-1:0]   addr_q;
  logic [DATAWIDTH-1:0]   data_q;
  logic                   we_q;
  logic                   trig_evt;
  logic                   accept;
  logic                   start;
  logic                   dec_hit;

  capture_trig_detect u_trig (
    .clk       (clk),
    .reset     (reset),
    .armed     (state_q == ARMED),
    .trig_mode (trig_mode),
    .trig_in   (trig_in),
    .sw_trig   (sw_trig),
    .trig_evt  (trig_evt)
  );

`ifdef CAPTURE_DECIM_EN
  logic [DECIMWIDTH-1:0] decim_q;
  logic [DECIMWIDTH-1:0] dec_cnt_q;

  assign dec_hit = (dec_cnt_q == '0);

  // Decimation down-counter: reloaded on every accepted sample, counts down between them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decim_q   <= '0;
      dec_cnt_q <= '0;
    end else begin
      if (start) decim_q <= decim;
      if (accept) begin
        dec_cnt_q <= decim_q;
      end else if (state_q == CAPTURE && dec_cnt_q != '0) begin
        dec_cnt_q <= dec_cnt_q - {{(DECIMWIDTH-1){1'b0}}, 1'b1};
      end
    end
  end
`else
  assign dec_hit = 1'b1;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus sample-accept and arm-start strobes; abort overrides everything
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d = ARMED;
          start   = 1'b1;
        end
      end
      ARMED: begin
        // Trigger cycle's din is sample 0
        if (trig_evt) begin
          state_d = CAPTURE;
          accept  = 1'b1;
        end
      end
      CAPTURE: begin
        // wr_count reaches nsamp in the cycle the final write is visible
        if (wr_count_q == nsamp_q) begin
          state_d = DONE;
        end else begin
          accept = dec_hit;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      accept  = 1'b0;
      start   = 1'b0;
    end
  end

  // Write port registers: one-cycle din-to-BRAM latency, address and data hold between writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nsamp_q    <= '0;
      wr_count_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
    end else begin
      we_q <= accept;
      if (start) begin
        wr_count_q <= '0;
        nsamp_q    <= clamp_nsamp(nsamp);
      end
      if (accept) begin
        addr_q     <= wr_count_q[ADDRWIDTH-1:0];
        data_q     <= din;
        wr_count_q <= wr_count_q + CntOne;
      end
    end
  end

  assign bram_addr = addr_q;
  assign bram_data = data_q;
  assign bram_we   = {WeWidth{we_q}};
  assign busy      = (state_q == ARMED) || (state_q == CAPTURE);
  assign done      = (state_q == DONE);
  assign wr_count  = wr_count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Self-checking bench for bram_capture_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a cycle-arithmetic reference model.
// Build with +define+CAPTURE_DECIM_EN to exercise decimation.
module tb_bram_capture_ctrl;

  localparam int AW    = 13;
  localparam int DW    = 64;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trig_mode = 1'b0;
  logic          trig_in = 1'b0;
  logic          sw_trig = 1'b0;
  logic [AW:0]   nsamp = '0;
  logic [7:0]    decim_drv = '0;
  logic [DW-1:0] din = '0;

  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   bram_data;
  logic [DW/8-1:0] bram_we;
  logic            busy;
  logic            done;
  logic [AW:0]     wr_count;
  logic [1:0]      state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_din = 1'b0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bram_capture_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .arm       (arm),
    .abort     (abort),
    .trig_mode (trig_mode),
    .trig_in   (trig_in),
    .sw_trig   (sw_trig),
    .nsamp     (nsamp),
`ifdef CAPTURE_DECIM_EN
    .decim     (decim_drv),
`endif
    .din       (din),
    .bram_addr (bram_addr),
    .bram_data (bram_data),
    .bram_we   (bram_we),
    .busy      (busy),
    .done      (done),
    .wr_count  (wr_count),
    .state     (state)
  );

  // Reference model: capture described as a trigger time plus sample index arithmetic
  int          m_state = 0;
  int          m_cnt = 0;
  int          m_addr = 0;
  int          m_n = 0;
  int          m_step = 1;
  int          t_trig = 0;
  int          rel = 0;
  int          m_j = 0;
  bit          m_acc = 1'b0;
  bit          m_we = 1'b0;
  bit          m_prev = 1'b0;
  logic [63:0] m_data = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = 0; m_cnt = 0; m_addr = 0; m_n = 0; m_step = 1;
      m_we = 1'b0; m_prev = 1'b0; m_data = '0;
    end else begin
      m_acc = 1'b0;
      m_j = 0;
      if (abort) begin
        m_state = 0;
      end else if (m_state == 0 || m_state == 3) begin
        if (arm) begin
          m_state = 1;
          m_cnt = 0;
          m_n = (nsamp == 0 || int'(nsamp) > DEPTH) ? DEPTH : int'(nsamp);
`ifdef CAPTURE_DECIM_EN
          m_step = int'(decim_drv) + 1;
`else
          m_step = 1;
`endif
        end
      end else if (m_state == 1) begin
        if (sw_trig || !trig_mode || (trig_in && !m_prev)) begin
          m_state = 2;
          t_trig = cyc;
          m_acc = 1'b1;
        end
      end else begin
        rel = cyc - t_trig;
        if (rel == (m_n - 1) * m_step + 1) m_state = 3;
        else if (rel % m_step == 0 && rel / m_step < m_n) begin
          m_acc = 1'b1;
          m_j = rel / m_step;
        end
      end
      m_we = m_acc;
      if (m_acc) begin
        m_addr = m_j;
        m_data = din;
        m_cnt = m_j + 1;
      end
      m_prev = trig_in;
      cyc++;
    end
  end

  // Every mid-cycle, all outputs must match the model
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      checks++;
      if (int'(state) != m_state || bram_we !== {8{m_we}} || int'(bram_addr) != m_addr ||
          bram_data !== m_data || int'(wr_count) != m_cnt ||
          busy !== (m_state == 1 || m_state == 2) || done !== (m_state == 3)) begin
        errors++;
        $display("FAIL model cyc=%0d actual/required state=%0d/%0d we=%0h/%0b addr=%0d/%0d data=%0h/%0h cnt=%0d/%0d busy=%0b done=%0b",
                 cyc, state, m_state, bram_we, m_we, bram_addr, m_addr, bram_data, m_data,
                 wr_count, m_cnt, busy, done);
      end
    end
  end

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    arm = 1'b0;
    abort = 1'b0;
    sw_trig = 1'b0;
    din = rand_din ? {$urandom, $urandom} : 64'(cyc);
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    lit(name, 64'(seen), 64'd1);
  endtask

  task automatic run_full(input logic [AW:0] n, input string tag);
    int writes = 0;
    int last = -1;
    bit wrapped = 1'b0;
    bit seen = 1'b0;
    trig_mode = 1'b0;
    nsamp = n;
    arm = 1'b1;
    tick();
    for (int i = 0; i < DEPTH + 100 && !seen; i++) begin
      tick();
      if (bram_we[0]) begin
        if (int'(bram_addr) != last + 1) wrapped = 1'b1;
        last = int'(bram_addr);
        writes++;
      end
      if (done) seen = 1'b1;
    end
    lit({tag, "_done"}, 64'(seen), 64'd1);
    lit({tag, "_writes"}, 64'(writes), 64'(DEPTH));
    lit({tag, "_last_addr"}, 64'(last), 64'(DEPTH - 1));
    lit({tag, "_wr_count"}, 64'(wr_count), 64'(DEPTH));
    lit({tag, "_no_wrap"}, 64'(wrapped), 64'd0);
    abort = 1'b1;
    tick();
  endtask

  int a;
  int e;
`ifdef CAPTURE_DECIM_EN
  logic [63:0] cap_data [8];
  int nw;
`endif

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    lit("rst_state", 64'(state), 64'd0);
    lit("rst_we", 64'(bram_we), 64'd0);
    lit("rst_addr", 64'(bram_addr), 64'd0);
    lit("rst_data", bram_data, 64'd0);
    lit("rst_count", 64'(wr_count), 64'd0);
    lit("rst_busy_done", {busy, done}, 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Immediate trigger, 4 samples
    trig_mode = 1'b0;
    nsamp = 4;
    tick();
    a = cyc;
    arm = 1'b1;
    repeat (5) tick();
    lit("imm_we", 64'(bram_we), 64'hff);
    lit("imm_addr", 64'(bram_addr), 64'd3);
    lit("imm_data", bram_data, 64'(a + 4));
    lit("imm_count", 64'(wr_count), 64'd4);
    tick();
    lit("imm_done", 64'(done), 64'd1);
    lit("imm_state", 64'(state), 64'd3);
    lit("imm_we_off", 64'(bram_we), 64'd0);
    lit("imm_busy", 64'(busy), 64'd0);
    lit("imm_addr_hold", 64'(bram_addr), 64'd3);

    // External edge: level high at arm is not a trigger
    trig_mode = 1'b1;
    nsamp = 8;
    tick();
    trig_in = 1'b1;
    arm = 1'b1;
    repeat (3) tick();
    trig_in = 1'b0;
    repeat (4) tick();
    lit("ext_wait_state", 64'(state), 64'd1);
    lit("ext_wait_we", 64'(bram_we), 64'd0);
    trig_in = 1'b1;
    e = cyc;
    tick();
    lit("ext_first_we", 64'(bram_we), 64'hff);
    lit("ext_first_addr", 64'(bram_addr), 64'd0);
    lit("ext_first_data", bram_data, 64'(e));
    wait_done(20, "ext_done");
    lit("ext_count", 64'(wr_count), 64'd8);
    abort = 1'b1;
    tick();

    // Full depth, via zero and via an oversized request
    run_full('0, "full0");
    run_full(9000, "full9000");

    // Abort after 37 writes, then re-arm
    trig_mode = 1'b0;
    nsamp = 100;
    tick();
    arm = 1'b1;
    repeat (38) tick();
    lit("abt_pre_count", 64'(wr_count), 64'd37);
    abort = 1'b1;
    tick();
    lit("abt_state", 64'(state), 64'd0);
    lit("abt_we", 64'(bram_we), 64'd0);
    lit("abt_count", 64'(wr_count), 64'd37);
    lit("abt_done", 64'(done), 64'd0);
    arm = 1'b1;
    repeat (2) tick();
    lit("rearm_addr", 64'(bram_addr), 64'd0);
    lit("rearm_count", 64'(wr_count), 64'd1);
    abort = 1'b1;
    tick();

    // arm + abort together in IDLE
    arm = 1'b1;
    abort = 1'b1;
    tick();
    lit("armabort_state", 64'(state), 64'd0);

    // sw_trig in the arm cycle is ignored
    trig_mode = 1'b1;
    trig_in = 1'b0;
    nsamp = 3;
    tick();
    arm = 1'b1;
    sw_trig = 1'b1;
    repeat (2) tick();
    lit("swarm_state", 64'(state), 64'd1);
    lit("swarm_we", 64'(bram_we), 64'd0);
    sw_trig = 1'b1;
    repeat (2) tick();
    lit("sw_first_we", 64'(bram_we), 64'hff);
    abort = 1'b1;
    tick();

    // arm during capture is ignored
    trig_mode = 1'b0;
    nsamp = 6;
    arm = 1'b1;
    repeat (3) tick();
    arm = 1'b1;
    nsamp = 2;
    wait_done(20, "midarm_done");
    lit("midarm_count", 64'(wr_count), 64'd6);
    lit("midarm_addr", 64'(bram_addr), 64'd5);

    // Reset mid-capture clears outputs without a clock edge
    nsamp = 50;
    arm = 1'b1;
    repeat (10) tick();
    reset = 1'b1;
    #1;
    lit("rstmid_we", 64'(bram_we), 64'd0);
    lit("rstmid_state", 64'(state), 64'd0);
    lit("rstmid_count", 64'(wr_count), 64'd0);
    lit("rstmid_addr_data", 64'(bram_addr) | bram_data, 64'd0);
    tick();
    reset = 1'b0;
    tick();

`ifdef CAPTURE_DECIM_EN
    // Decimation: keep 1 of 4
    decim_drv = 8'd3;
    nsamp = 5;
    trig_mode = 1'b0;
    tick();
    a = cyc;
    arm = 1'b1;
    nw = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (bram_we[0]) begin
        cap_data[bram_addr[2:0]] = bram_data;
        nw++;
      end
    end
    lit("dec_writes", 64'(nw), 64'd5);
    for (int j = 0; j < 5; j++) lit("dec_data", cap_data[j], 64'(a + 1 + 4 * j));
    decim_drv = '0;
    abort = 1'b1;
    tick();
`endif

    // Randomized traffic against the model
    rand_din = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      arm = ($urandom % 8) == 0;
      abort = ($urandom % 70) == 0;
      sw_trig = ($urandom % 24) == 0;
      if ($urandom % 50 == 0) trig_mode = ~trig_mode;
      if ($urandom % 3 == 0) trig_in = 1'($urandom % 2);
      nsamp = ($urandom % 20 == 0) ? (AW + 1)'($urandom) : (AW + 1)'($urandom_range(1, 24));
`ifdef CAPTURE_DECIM_EN
      decim_drv = 8'($urandom_range(0, 3));
`endif
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_capture_ctrl.md
Name: bram_capture_ctrl

Overview:
- Arm/trigger/capture sequencer for a to-host BRAM port (bramtohost*_addr/_we/_data) of the dsp block.
- Replaces free-running address counters: after arm, waits for a trigger, then writes exactly N samples of a selected dsp stream (ADC, cordic, cmultiplier steps).
- Host reads the buffer once done is set.
- Sits between the dsp data mux and the BRAM port; control comes from dsp register bits.

Parameters:
- ADDRWIDTH, 13: BRAM address width; depth = 2^ADDRWIDTH words.
- DATAWIDTH, 64: sample and BRAM word width.
- DECIMWIDTH, 8: decimation field width (used only with CAPTURE_DECIM_EN).

Ports:
- clk  in  1  dsp clock.
- reset  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle pulse; starts a capture sequence.
- abort  in  1  single-cycle pulse; returns to IDLE from any state.
- trig_mode  in  1  0 = immediate start, 1 = start on external trigger edge.
- trig_in  in  1  external trigger level, already in the clk domain.
- sw_trig  in  1  single-cycle software trigger pulse.
- nsamp  in  ADDRWIDTH+1  samples to capture; sampled on arm.
- decim  in  DECIMWIDTH  keep 1 of every decim+1 samples; present only with CAPTURE_DECIM_EN.
- din  in  DATAWIDTH  sample stream, valid every cycle.
- bram_addr  out  ADDRWIDTH  BRAM write address.
- bram_data  out  DATAWIDTH  BRAM write data.
- bram_we  out  DATAWIDTH/8  byte write enables, all bits equal.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- wr_count  out  ADDRWIDTH+1  number of words written in the current capture.
- state  out  2  current state, for the debug register.

Behaviour:
- Reset (asynchronous):
  - state = IDLE.
  - All outputs 0.
  - Internal nsamp latch = 0, trigger-edge register = 0.
- State encoding: IDLE = 0, ARMED = 1, CAPTURE = 2, DONE = 3.
- IDLE, or DONE, with arm:
  - Go to ARMED next cycle.
  - Clear wr_count and done.
  - Latch nsamp_eff:
    - nsamp = 0 → 2^ADDRWIDTH.
    - nsamp > 2^ADDRWIDTH → clamped to 2^ADDRWIDTH.
- ARMED, trigger event:
  - Sources: sw_trig = 1; OR trig_mode = 0; OR (trig_mode = 1 AND trig_in rising edge, i.e. trig_in = 1 with the registered previous value = 0).
  - On the event, go to CAPTURE. The din value in the trigger cycle is sample 0.
- A trigger in the same cycle as arm is ignored; arm takes effect first.
- CAPTURE:
  - Each accepted sample k appears one cycle later as bram_addr = k, bram_data = din, bram_we = all ones.
  - wr_count = k+1 in that same cycle.
  - Fixed latency: din to BRAM write is 1 cycle.
- bram_we is 0 in every cycle with no accepted write.
- The last write has k = nsamp_eff-1:
  - state = DONE in the cycle after that write.
  - done = 1, busy = 0.
  - bram_addr holds its last value.
- Full depth: address 2^ADDRWIDTH-1 is the final write. The address never wraps, so words are never overwritten.
- abort:
  - From any state, go to IDLE next cycle; bram_we = 0 from then on.
  - wr_count holds its value for host inspection; done = 0.
  - abort and arm in the same cycle: abort wins.
- arm in ARMED or CAPTURE is ignored; no restart mid-capture.
- nsamp changes after arm have no effect until the next arm.
- Reset mid-capture: immediate return to IDLE; bram_we drops asynchronously.

Optional Feature:
- Macro: CAPTURE_DECIM_EN.
- Defined:
  - decim port exists and is latched on arm.
  - In CAPTURE, a sample is accepted on the trigger cycle and then every decim+1 cycles, via an internal down-counter reloaded with the latched decim.
  - decim = 0 means every cycle.
  - Latency and termination rules are unchanged.
- Undefined:
  - No decim port, no counter.
  - Every CAPTURE cycle is accepted.

Decomposition:
- Package dsp_capture_pkg holds:
  - typedef enum logic [1:0] capture_state_t (IDLE, ARMED, CAPTURE, DONE).
  - Default width constants CAP_ADDRWIDTH = 13 and CAP_DATAWIDTH = 64.
- One sub-module: capture_trig_detect. It holds the edge register and mode/sw_trig merge, and outputs a single-cycle trig_evt.
- The FSM, address counter and decimation counter stay in bram_capture_ctrl.

Test Plan:
- Immediate capture: trig_mode = 0, nsamp = 4, din = cycle counter, arm at t0.
  - Expect we high for 4 cycles, addr 0..3, data = din one cycle earlier.
  - Expect done = 1 and wr_count = 4, then we = 0.
- External edge: trig_mode = 1, trig_in held high at arm, then low, then high at t = 20, nsamp = 8.
  - Expect no writes before t = 20.
  - Expect sample 0 = din@20, written at t = 21.
- Full depth: nsamp = 0 (and separately nsamp = 9000).
  - Expect exactly 8192 writes, last addr = 8191, wr_count = 8192, no wrap.
- Abort mid-capture: nsamp = 100, abort after 37 writes.
  - Expect state = IDLE next cycle, we = 0, wr_count = 37, done = 0.
  - Re-arm then restarts at addr 0.
- Simultaneous events:
  - arm + abort in IDLE → stays IDLE.
  - arm during CAPTURE → ignored, count unaffected.
  - sw_trig in the arm cycle → ignored.
  - Reset asserted mid-capture → all outputs 0 immediately.
- CAPTURE_DECIM_EN with decim = 3, nsamp = 5, din = cycle counter.
  - Expect written data = din@T, T+4, T+8, T+12, T+16 at addr 0..4.
